// File: rtl/debug_pkg.sv
// debug_pkg -- shared types and constants for the debug register access block.
//
// Contents:
//   REG_ADDR_W   : width of a register index (x0..x31).
//   DBG_XLEN     : register data width carried by the captured request.
//                  The top-level XLEN parameter must match this value.
//   dbg_state_t  : FSM state encoding for debug_reg_ctrl.
//   dbg_req_t    : captured debug request (write, addr, wdata).
//   is_x0()      : true when a register index addresses the hardwired-zero x0.
package debug_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DBG_XLEN   = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        ACCESS    = 3'd2,
        RESP      = 3'd3,
        HOLD      = 3'd4,
        RESUME    = 3'd5
    } dbg_state_t;

    typedef struct packed {
        logic                  write;
        logic [REG_ADDR_W-1:0] addr;
        logic [DBG_XLEN-1:0]   wdata;
    } dbg_req_t;

    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/debug_halt_timer.sv
// debug_halt_timer -- counts cycles spent waiting for the pipeline to halt.
//
// Ports:
//   clk    : clock, rising edge.
//   rst    : synchronous active-high reset, clears the count.
//   start  : count enable; the counter advances while start=1 until it expires.
//   clear  : synchronous clear, restarts the count from zero.
//   expire : high while the count equals TIMEOUT.
//
// Parameters:
//   TIMEOUT : number of counted cycles before expire asserts.
module debug_halt_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_reg;

    assign expire = (cnt_reg == CNT_W'(TIMEOUT));

    // The count parks at TIMEOUT so expire stays asserted until cleared.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_reg <= '0;
        end else if (start && !expire) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/debug_reg_ctrl.sv
// debug_reg_ctrl -- debug access controller for the integer register file.
//
// A debug request halts the pipeline (halt_req / halted handshake), performs
// one register read or write through the register file's debug port, and
// returns a response. After a successful access the pipeline stays halted for
// one HOLD cycle so a follow-up request can go straight to ACCESS without
// re-halting. If the pipeline does not report halted within HALT_TIMEOUT
// cycles the request completes with dbg_rsp_err=1 and no register access.
//
// Ports:
//   clk, rst                      : clock and synchronous active-high reset.
//   dbg_req_valid/ready           : request handshake (ready only in IDLE/HOLD).
//   dbg_req_write/addr/wdata      : request fields.
//   dbg_rsp_valid/ready           : response handshake.
//   dbg_rsp_rdata, dbg_rsp_err    : read data (0 for writes/errors), timeout flag.
//   halt_req, halted              : pipeline stall request and acknowledge.
//   rf_raddr, rf_rdata            : register file debug read port (combinational data).
//   rf_we, rf_waddr, rf_wdata     : register file debug write port.
//   stat_access_cnt, stat_timeout_cnt : saturating statistics.
//
// Configuration:
//   DEBUG_REG_CTRL_STATS_EN : when defined, the statistics counters are built;
//                             otherwise the stat ports are tied to zero.
module debug_reg_ctrl
    import debug_pkg::*;
#(
    parameter int HALT_TIMEOUT = 255,
    parameter int XLEN         = DBG_XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic                  dbg_req_write,
    input  logic [REG_ADDR_W-1:0] dbg_req_addr,
    input  logic [XLEN-1:0]       dbg_req_wdata,
    output logic                  dbg_rsp_valid,
    input  logic                  dbg_rsp_ready,
    output logic [XLEN-1:0]       dbg_rsp_rdata,
    output logic                  dbg_rsp_err,
    output logic                  halt_req,
    input  logic                  halted,
    output logic [REG_ADDR_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]       rf_rdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [15:0]           stat_access_cnt,
    output logic [7:0]            stat_timeout_cnt
);

    dbg_state_t            state_reg, state_next;
    dbg_req_t              req_reg, req_next;
    logic                  halt_req_reg, halt_req_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic                  rsp_err_reg, rsp_err_next;
    logic [XLEN-1:0]       rsp_rdata_reg, rsp_rdata_next;
    logic                  rf_we_reg, rf_we_next;
    logic [REG_ADDR_W-1:0] rf_waddr_reg, rf_waddr_next;
    logic [XLEN-1:0]       rf_wdata_reg, rf_wdata_next;
    logic [REG_ADDR_W-1:0] rf_raddr_reg, rf_raddr_next;

    logic timer_start;
    logic timer_clear;
    logic timer_expire;

    debug_halt_timer #(
        .TIMEOUT (HALT_TIMEOUT)
    ) u_halt_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (timer_start),
        .clear  (timer_clear),
        .expire (timer_expire)
    );

    assign dbg_req_ready = (state_reg == IDLE) || (state_reg == HOLD);
    assign dbg_rsp_valid = rsp_valid_reg;
    assign dbg_rsp_err   = rsp_err_reg;
    assign dbg_rsp_rdata = rsp_rdata_reg;
    assign halt_req      = halt_req_reg;
    assign rf_we         = rf_we_reg;
    assign rf_waddr      = rf_waddr_reg;
    assign rf_wdata      = rf_wdata_reg;
    assign rf_raddr      = rf_raddr_reg;

    always_comb begin
        state_next     = state_reg;
        req_next       = req_reg;
        halt_req_next  = halt_req_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_err_next   = rsp_err_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rf_we_next     = 1'b0;
        rf_waddr_next  = rf_waddr_reg;
        rf_wdata_next  = rf_wdata_reg;
        rf_raddr_next  = rf_raddr_reg;
        timer_start    = 1'b0;
        timer_clear    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (dbg_req_valid) begin
                    req_next.write = dbg_req_write;
                    req_next.addr  = dbg_req_addr;
                    req_next.wdata = dbg_req_wdata;
                    rf_raddr_next  = dbg_req_addr;
                    halt_req_next  = 1'b1;
                    timer_clear    = 1'b1;
                    state_next     = HALT_WAIT;
                end
            end

            HALT_WAIT: begin
                timer_start = 1'b1;
                if (halted) begin
                    // The write strobe is registered, so it is armed here and
                    // is high for exactly the ACCESS cycle. halted was seen
                    // high and halt_req stays asserted, so the pipeline is
                    // still halted when the strobe is out.
                    rf_we_next = req_reg.write && !is_x0(req_reg.addr);
                    if (req_reg.write) begin
                        rf_waddr_next = req_reg.addr;
                        rf_wdata_next = req_reg.wdata;
                    end
                    state_next = ACCESS;
                end else if (timer_expire) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = '0;
                    halt_req_next  = 1'b0;
                    state_next     = RESP;
                end
            end

            ACCESS: begin
                rsp_valid_next = 1'b1;
                rsp_err_next   = 1'b0;
                rsp_rdata_next = (!req_reg.write && !is_x0(req_reg.addr)) ? rf_rdata : '0;
                state_next     = RESP;
            end

            RESP: begin
                if (dbg_rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    // The error flag marks the timeout path, where halt_req
                    // has already been dropped and there is nothing to hold.
                    state_next     = rsp_err_reg ? IDLE : HOLD;
                end
            end

            HOLD: begin
                if (dbg_req_valid) begin
                    req_next.write = dbg_req_write;
                    req_next.addr  = dbg_req_addr;
                    req_next.wdata = dbg_req_wdata;
                    rf_raddr_next  = dbg_req_addr;
                    if (halted) begin
                        rf_we_next = dbg_req_write && !is_x0(dbg_req_addr);
                        if (dbg_req_write) begin
                            rf_waddr_next = dbg_req_addr;
                            rf_wdata_next = dbg_req_wdata;
                        end
                        state_next = ACCESS;
                    end else begin
                        // Pipeline unexpectedly left halt: wait again with
                        // halt_req still asserted rather than access blind.
                        timer_clear = 1'b1;
                        state_next  = HALT_WAIT;
                    end
                end else begin
                    halt_req_next = 1'b0;
                    state_next    = RESUME;
                end
            end

            RESUME: begin
                if (!halted) begin
                    state_next = IDLE;
                end
            end

            default: begin
                halt_req_next  = 1'b0;
                rsp_valid_next = 1'b0;
                state_next     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            req_reg       <= '0;
            halt_req_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            rf_we_reg     <= 1'b0;
            rf_waddr_reg  <= '0;
            rf_wdata_reg  <= '0;
            rf_raddr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            req_reg       <= req_next;
            halt_req_reg  <= halt_req_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rf_we_reg     <= rf_we_next;
            rf_waddr_reg  <= rf_waddr_next;
            rf_wdata_reg  <= rf_wdata_next;
            rf_raddr_reg  <= rf_raddr_next;
        end
    end

`ifdef DEBUG_REG_CTRL_STATS_EN
    logic [15:0] access_cnt_reg;
    logic [7:0]  timeout_cnt_reg;
    logic        timeout_event;

    assign timeout_event = (state_reg == HALT_WAIT) && !halted && timer_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            access_cnt_reg  <= '0;
            timeout_cnt_reg <= '0;
        end else begin
            if ((state_reg == ACCESS) && (access_cnt_reg != '1)) begin
                access_cnt_reg <= access_cnt_reg + 16'd1;
            end
            if (timeout_event && (timeout_cnt_reg != '1)) begin
                timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
            end
        end
    end

    assign stat_access_cnt  = access_cnt_reg;
    assign stat_timeout_cnt = timeout_cnt_reg;
`else
    assign stat_access_cnt  = '0;
    assign stat_timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_debug_reg_ctrl.sv
// tb_debug_reg_ctrl -- directed self-checking bench for debug_reg_ctrl.
// The DUT is built with HALT_TIMEOUT=4; a small register file model answers
// the debug read port and absorbs writes. Statistics expectations follow
// DEBUG_REG_CTRL_STATS_EN.
module tb_debug_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_req_valid;
    logic        dbg_req_ready;
    logic        dbg_req_write;
    logic [4:0]  dbg_req_addr;
    logic [31:0] dbg_req_wdata;
    logic        dbg_rsp_valid;
    logic        dbg_rsp_ready;
    logic [31:0] dbg_rsp_rdata;
    logic        dbg_rsp_err;
    logic        halt_req;
    logic        halted;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] stat_access_cnt;
    logic [7:0]  stat_timeout_cnt;

    int checks = 0;
    int errors = 0;

    // Monitors
    int          we_cnt = 0;
    int          we_bad = 0;
    logic [4:0]  we_addr;
    logic [31:0] we_data;
    bit          mon_en = 1'b0;
    int          hl_cnt = 0;

    int exp_acc = 0;
    int exp_to  = 0;

    logic [31:0] rf_mem [32];

    always #5 clk = ~clk;

    debug_reg_ctrl #(
        .HALT_TIMEOUT (4),
        .XLEN         (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .dbg_req_valid    (dbg_req_valid),
        .dbg_req_ready    (dbg_req_ready),
        .dbg_req_write    (dbg_req_write),
        .dbg_req_addr     (dbg_req_addr),
        .dbg_req_wdata    (dbg_req_wdata),
        .dbg_rsp_valid    (dbg_rsp_valid),
        .dbg_rsp_ready    (dbg_rsp_ready),
        .dbg_rsp_rdata    (dbg_rsp_rdata),
        .dbg_rsp_err      (dbg_rsp_err),
        .halt_req         (halt_req),
        .halted           (halted),
        .rf_raddr         (rf_raddr),
        .rf_rdata         (rf_rdata),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .stat_access_cnt  (stat_access_cnt),
        .stat_timeout_cnt (stat_timeout_cnt)
    );

    assign rf_rdata = rf_mem[rf_raddr];

    always @(posedge clk) begin
        if (rf_we === 1'b1) rf_mem[rf_waddr] <= rf_wdata;
    end

    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            we_cnt  = we_cnt + 1;
            we_addr = rf_waddr;
            we_data = rf_wdata;
            if (halted !== 1'b1) we_bad = we_bad + 1;
        end
        if (mon_en && halt_req !== 1'b1) hl_cnt = hl_cnt + 1;
    end

    task automatic send_req(input logic w, input logic [4:0] a, input logic [31:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        dbg_req_valid = 1'b1;
        dbg_req_write = w;
        dbg_req_addr  = a;
        dbg_req_wdata = d;
        while (dbg_req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++; errors++;
            $display("FAIL req_accept: ready=%b after %0d cycles, required 1", dbg_req_ready, guard);
        end
        @(posedge clk);
        #1;
        dbg_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input bit consume, output logic [31:0] rd, output logic er, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (dbg_rsp_valid !== 1'b1 && lat < 50);
        if (dbg_rsp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", dbg_rsp_valid, lat);
        end
        rd = dbg_rsp_rdata;
        er = dbg_rsp_err;
        $display("txn: addr=%0d write=%0b rdata=%h err=%0b latency=%0d",
                 dbg_req_addr, dbg_req_write, rd, er, lat);
        if (consume) begin
            dbg_rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            dbg_rsp_ready = 1'b0;
        end
    endtask

    // Let the pipeline resume and wait until the controller is back in IDLE.
    task automatic release_halt();
        int guard;
        guard = 0;
        @(negedge clk);
        halted = 1'b0;
        while (!(dbg_req_ready === 1'b1 && halt_req === 1'b0) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL resume_idle: halt_req=%b ready=%b, required 0/1", halt_req, dbg_req_ready);
        end
        halted = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dbg_req_ready !== 1'b1 || halt_req !== 1'b0 || dbg_rsp_valid !== 1'b0 ||
            dbg_rsp_err !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b halt_req=%b rsp_valid=%b err=%b rf_we=%b, required 1 0 0 0 0",
                     dbg_req_ready, halt_req, dbg_rsp_valid, dbg_rsp_err, rf_we);
        end
        checks++;
        if (dbg_rsp_rdata !== 32'h0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0 || rf_raddr !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h waddr=%0d wdata=%h raddr=%0d, required all 0",
                     dbg_rsp_rdata, rf_waddr, rf_wdata, rf_raddr);
        end
        checks++;
        if (stat_access_cnt !== 16'd0 || stat_timeout_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_stats: acc=%0d to=%0d, required 0 0", stat_access_cnt, stat_timeout_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_read();
        logic [31:0] rd; logic er; int lat;
        send_req(1'b0, 5'd5, 32'h0);
        wait_rsp(1'b1, rd, er, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL read_latency: got %0d, required 3", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_x5: rdata=%h, required deadbeef", rd); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL read_err: err=%b, required 0", er); end
        release_halt();
        exp_acc++;
    endtask

    task automatic test_write();
        logic [31:0] rd; logic [31:0] rd0; logic er; int lat; int unstable;
        we_cnt = 0;
        send_req(1'b1, 5'd7, 32'h12345678);
        wait_rsp(1'b1, rd, er, lat);
        checks++;
        if (we_cnt != 1) begin errors++; $display("FAIL write_we_cycles: got %0d, required 1", we_cnt); end
        checks++;
        if (we_addr !== 5'd7 || we_data !== 32'h12345678) begin
            errors++;
            $display("FAIL write_port: waddr=%0d wdata=%h, required 7 12345678", we_addr, we_data);
        end
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL write_rsp: err=%b rdata=%h, required 0 0", er, rd);
        end
        release_halt();
        // Read back and leave the response unconsumed for 10 cycles.
        send_req(1'b0, 5'd7, 32'h0);
        wait_rsp(1'b0, rd0, er, lat);
        unstable = 0;
        repeat (10) begin
            @(negedge clk);
            if (dbg_rsp_valid !== 1'b1 || dbg_rsp_rdata !== rd0) unstable++;
        end
        checks++;
        if (rd0 !== 32'h12345678) begin errors++; $display("FAIL readback_x7: rdata=%h, required 12345678", rd0); end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL rsp_stable: %0d unstable cycles, required 0", unstable); end
        dbg_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        dbg_rsp_ready = 1'b0;
        release_halt();
        exp_acc += 2;
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic er; int lat;
        we_cnt = 0;
        halted = 1'b0;
        send_req(1'b1, 5'd9, 32'hCAFEF00D);
        wait_rsp(1'b0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL timeout_rsp: err=%b rdata=%h, required 1 0", er, rd);
        end
        checks++;
        if (halt_req !== 1'b0) begin errors++; $display("FAIL timeout_halt_req: got %b, required 0", halt_req); end
        dbg_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        dbg_rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_req_ready !== 1'b1 || halt_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: ready=%b halt_req=%b, required 1 0", dbg_req_ready, halt_req);
        end
        checks++;
        if (we_cnt != 0 || rf_mem[9] !== 32'h0) begin
            errors++;
            $display("FAIL timeout_no_write: we_cycles=%0d x9=%h, required 0 0", we_cnt, rf_mem[9]);
        end
        halted = 1'b1;
        exp_to++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat;
        hl_cnt = 0;
        send_req(1'b0, 5'd5, 32'h0);
        mon_en = 1'b1;
        wait_rsp(1'b0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_first: rdata=%h, required deadbeef", rd); end
        // Consume the response and present the next request for the HOLD cycle.
        dbg_rsp_ready = 1'b1;
        dbg_req_valid = 1'b1;
        dbg_req_write = 1'b0;
        dbg_req_addr  = 5'd7;
        dbg_req_wdata = 32'h0;
        @(posedge clk);
        #1;
        dbg_rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_hold_ready: got %b, required 1", dbg_req_ready); end
        @(posedge clk);
        #1;
        dbg_req_valid = 1'b0;
        wait_rsp(1'b1, rd, er, lat);
        mon_en = 1'b0;
        checks++;
        if (lat != 2) begin errors++; $display("FAIL b2b_latency: got %0d, required 2", lat); end
        checks++;
        if (rd !== 32'h12345678) begin errors++; $display("FAIL b2b_second: rdata=%h, required 12345678", rd); end
        checks++;
        if (hl_cnt != 0) begin errors++; $display("FAIL b2b_halt_held: halt_req low %0d cycles, required 0", hl_cnt); end
        release_halt();
        exp_acc += 2;
    endtask

    task automatic test_x0();
        logic [31:0] rd; logic er; int lat;
        we_cnt = 0;
        send_req(1'b1, 5'd0, 32'hFFFFFFFF);
        wait_rsp(1'b1, rd, er, lat);
        checks++;
        if (we_cnt != 0) begin errors++; $display("FAIL x0_write_we: we_cycles=%0d, required 0", we_cnt); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL x0_write_err: err=%b, required 0", er); end
        release_halt();
        send_req(1'b0, 5'd0, 32'h0);
        wait_rsp(1'b1, rd, er, lat);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL x0_read: rdata=%h, required 0", rd); end
        release_halt();
        exp_acc += 2;
    endtask

    task automatic test_stats();
        int want_acc; int want_to;
`ifdef DEBUG_REG_CTRL_STATS_EN
        want_acc = exp_acc;
        want_to  = exp_to;
`else
        want_acc = 0;
        want_to  = 0;
`endif
        checks++;
        if (int'(stat_access_cnt) != want_acc) begin
            errors++;
            $display("FAIL stat_access: got %0d, required %0d", stat_access_cnt, want_acc);
        end
        checks++;
        if (int'(stat_timeout_cnt) != want_to) begin
            errors++;
            $display("FAIL stat_timeout: got %0d, required %0d", stat_timeout_cnt, want_to);
        end
    endtask

    task automatic test_reset_in_access();
        send_req(1'b0, 5'd5, 32'h0);
        @(negedge clk);          // HALT_WAIT
        @(negedge clk);          // ACCESS
        checks++;
        if (halt_req !== 1'b1) begin errors++; $display("FAIL rst_pre_halt_req: got %b, required 1", halt_req); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_req_ready !== 1'b1 || halt_req !== 1'b0 || dbg_rsp_valid !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_access: ready=%b halt_req=%b rsp_valid=%b rf_we=%b, required 1 0 0 0",
                     dbg_req_ready, halt_req, dbg_rsp_valid, rf_we);
        end
        exp_acc = 0;
        exp_to  = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
        rf_mem[0] = 32'hA5A5A5A5;
        rf_mem[5] = 32'hDEADBEEF;
        rst           = 1'b1;
        dbg_req_valid = 1'b0;
        dbg_req_write = 1'b0;
        dbg_req_addr  = 5'd0;
        dbg_req_wdata = 32'h0;
        dbg_rsp_ready = 1'b0;
        halted        = 1'b1;

        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_back_to_back();
        test_x0();
        test_stats();
        test_reset_in_access();
        test_stats();
        test_read();
        test_stats();

        checks++;
        if (we_bad != 0) begin
            errors++;
            $display("FAIL we_without_halted: %0d cycles, required 0", we_bad);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
